// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multi-cycle ALU:
//     - DATA_W            : datapath width
//     - ALU_* constants   : ALUControl operation codes
//     - state_t           : FSM state enumeration (IDLE, CALC, SHIFT)
//     - is_shift()        : true for the codes that take the iterative shift path
//   Optional feature macro: ALU_SLTU_EN (see alu_core). Code 1010 is always
//   defined here so decoders and benches can name it in either build.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_ADDR = 4'b1001;  // load/store address add
   localparam logic [3:0] ALU_SLTU = 4'b1010;  // only decoded with ALU_SLTU_EN

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   // Shifts run one bit per cycle; everything else is single-cycle.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Purely combinational single-cycle operations of the multi-cycle ALU.
//   Shift codes and unlisted codes give 0 here; shifts are iterated in the
//   parent (multi_cycle_alu), so this block never sees them on a used path.
//
//   Ports:
//     i_op     [3:0]   operation code (latched ALUControl)
//     i_a      [31:0]  first operand
//     i_b      [31:0]  second operand
//     o_result [31:0]  combinational result
//
//   Macro ALU_SLTU_EN: when defined, code 1010 computes unsigned
//   set-less-than; otherwise 1010 falls into the unlisted-code default (0).
// -----------------------------------------------------------------------------
import alu_pkg::*;

module alu_core (
   input  logic [3:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result
);

   logic w_slt;
   logic w_sltu;

   assign w_slt  = ($signed(i_a) < $signed(i_b));
   assign w_sltu = (i_a < i_b);

   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_ADD,
         ALU_ADDR: o_result = i_a + i_b;   // wraps, no carry out
         ALU_SUB:  o_result = i_a - i_b;   // wraps, no borrow out
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_slt};
`ifdef ALU_SLTU_EN
         ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_sltu};
`else
         ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_sltu & 1'b0};
`endif
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu
//   32-bit ALU with a small FSM. Single-cycle operations go IDLE->CALC->IDLE
//   (done one edge after the accepting edge). Shifts go IDLE->SHIFT and move
//   one bit per edge, so a shift by n completes n+1 edges after acceptance.
//
//   Handshake: start is sampled only in IDLE (busy=0). Accepting a start
//   latches ALUControl/SrcA/SrcB; inputs are ignored until the operation
//   ends. done is a one-cycle pulse in the cycle ALUResult/Zero first show
//   the new result; state is already IDLE then, so a new start may be
//   presented in that same cycle. reset aborts without a done pulse.
//
//   Ports:
//     clk              clock, rising edge
//     reset            synchronous active-high reset
//     start            operation request (sampled in IDLE)
//     ALUControl [3:0] operation code
//     SrcA      [31:0] first operand
//     SrcB      [31:0] second operand; SrcB[4:0] is the shift amount
//     busy             high whenever state != IDLE
//     done             one-cycle completion pulse
//     ALUResult [31:0] registered result, held until next completion/reset
//     Zero             registered (ALUResult == 0)
//     o_dbg_state      current FSM state, for observation only
//
//   Macro ALU_SLTU_EN enables unsigned set-less-than on code 1010 (alu_core).
// -----------------------------------------------------------------------------
import alu_pkg::*;

module multi_cycle_alu (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        ALUControl,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] ALUResult,
   output logic              Zero,
   output state_t            o_dbg_state
);

   // Registered state
   state_t            r_state;
   logic [3:0]        r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_work;
   logic [4:0]        r_count;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;
   logic              r_done;

   // Next-state values
   state_t            w_state;
   logic [3:0]        w_op;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_work;
   logic [4:0]        w_count;
   logic [DATA_W-1:0] w_result;
   logic              w_zero;
   logic              w_done;

   logic [DATA_W-1:0] w_core_result;
   logic [DATA_W-1:0] w_shift_step;

   alu_core u_alu_core (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_core_result)
   );

   // One-bit step of the working register. sra replicates bit 31 of the
   // working value each step, so repeated steps equal an n-bit arithmetic shift.
   always_comb begin
      w_shift_step = r_work;
      case (r_op)
         ALU_SLL: w_shift_step = {r_work[DATA_W-2:0], 1'b0};
         ALU_SRL: w_shift_step = {1'b0, r_work[DATA_W-1:1]};
         ALU_SRA: w_shift_step = {r_work[DATA_W-1], r_work[DATA_W-1:1]};
         default: w_shift_step = r_work;
      endcase
   end

   // Next-state / datapath control
   always_comb begin
      w_state  = r_state;
      w_op     = r_op;
      w_a      = r_a;
      w_b      = r_b;
      w_work   = r_work;
      w_count  = r_count;
      w_result = r_result;
      w_zero   = r_zero;
      w_done   = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_op = ALUControl;
               w_a  = SrcA;
               w_b  = SrcB;
               if (is_shift(ALUControl)) begin
                  w_work  = SrcA;
                  w_count = SrcB[4:0];
                  w_state = SHIFT;
               end else begin
                  w_state = CALC;
               end
            end
         end

         CALC: begin
            w_result = w_core_result;
            w_zero   = (w_core_result == '0);
            w_done   = 1'b1;
            w_state  = IDLE;
         end

         SHIFT: begin
            if (r_count != 5'd0) begin
               w_work  = w_shift_step;
               w_count = r_count - 5'd1;
            end else begin
               w_result = r_work;
               w_zero   = (r_work == '0);
               w_done   = 1'b1;
               w_state  = IDLE;
            end
         end

         default: w_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_op     <= w_op;
         r_a      <= w_a;
         r_b      <= w_b;
         r_work   <= w_work;
         r_count  <= w_count;
         r_result <= w_result;
         r_zero   <= w_zero;
         r_done   <= w_done;
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign ALUResult   = r_result;
   assign Zero        = r_zero;
   assign o_dbg_state = r_state;

endmodule

// File: doc/multi_cycle_alu.md
MULTI_CYCLE_ALU -- requirements
Module: multi_cycle_alu

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-004 SHALL have port ALUControl, input, 4, operation code from the ALU decoder.
REQ-005 SHALL have port SrcA, input, 32, first operand.
REQ-006 SHALL have port SrcB, input, 32, second operand; SrcB[4:0] is shift amount for shifts.
REQ-007 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking ALUResult valid.
REQ-009 SHALL have port ALUResult, output, 32, registered result, held until next completion or reset.
REQ-010 SHALL have port Zero, output, 1, registered (ALUResult == 0), updated with ALUResult.

Function
REQ-011 SHALL decode ALUControl as: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 sll; 0101 signed set-less-than (result 1 or 0); 0110 xor; 0111 srl (logical); 1000 sra (arithmetic); 1001 add (load/store address).
REQ-012 SHALL produce ALUResult = 0 for any unlisted code, completing with non-shift latency.
REQ-013 SHALL use wrap-around 32-bit arithmetic for add/sub, with no overflow or carry output.
REQ-014 SHALL implement states IDLE, CALC, SHIFT.
REQ-015 IDLE with start=1 at edge k SHALL latch ALUControl, SrcA and SrcB, and go to SHIFT for codes 0100/0111/1000, otherwise to CALC.
REQ-016 CALC SHALL register the result, set done=1 and return to IDLE at edge k+1, giving non-shift latency 1 edge.
REQ-017 SHIFT SHALL load count = SrcB[4:0] at edge k, then shift the working register by exactly one bit per edge while count != 0, decrementing count each time.
REQ-018 SHIFT with count == 0 SHALL register the result, set done=1 and return to IDLE, so a shift of n completes at edge k+n+1, including n=0 at k+1.
REQ-019 sra shifting SHALL replicate bit 31 of the working register; srl and sll SHALL fill with zero.
REQ-020 SHALL ignore start while busy=1; latched operands are not disturbed by input changes during an operation.
REQ-021 SHALL assert done for exactly one cycle per accepted start.
REQ-022 SHALL accept a new start in the cycle done is high, since state is IDLE, giving back-to-back throughput of one operation per 2 edges for non-shift operations.

Reset
REQ-023 reset SHALL force state IDLE, busy=0, done=0, ALUResult=0, Zero=1 and count=0, taking priority over start.
REQ-024 reset during CALC or SHIFT SHALL abort the operation with no done pulse and no result update.

Configuration
REQ-025 With ALU_SLTU_EN defined, code 1010 SHALL compute unsigned set-less-than with non-shift latency.
REQ-026 Without ALU_SLTU_EN, code 1010 SHALL behave as an unlisted code (result 0).

Structure
REQ-027 Package alu_pkg SHALL hold the ALUControl code constants (including 1010) and the state enumeration.
REQ-028 Single-cycle operations SHALL be computed in a combinational sub-module alu_core, instantiated once.
REQ-029 The FSM, shift iteration and output registers SHALL reside in multi_cycle_alu.

Verification
REQ-030 ALUControl=0000, SrcA=5, SrcB=7, start at edge k -> done and ALUResult=12, Zero=0 at edge k+1; busy high one cycle.
REQ-031 ALUControl=0001, SrcA=SrcB=0x1234 -> ALUResult=0, Zero=1; then 0x0 minus 0x1 -> 0xFFFFFFFF.
REQ-032 ALUControl=1000, SrcA=0x80000000, SrcB=4 -> done at edge k+5 with ALUResult=0xF8000000; repeat with 0111 -> 0x08000000; 0100 with SrcB=0 -> done at k+1 with result = SrcA.
REQ-033 start pulsed again mid-shift with different operands -> ignored; original result delivered; one done pulse only.
REQ-034 reset asserted at edge k+2 of a 31-bit shift -> busy=0, done never pulses, ALUResult=0.
REQ-035 ALUControl=0101, SrcA=0xFFFFFFFF, SrcB=1 -> result 1; 1010 with the same operands -> 0 with ALU_SLTU_EN, 0 without it; 1010 with SrcA=1, SrcB=0xFFFFFFFF -> 1 with ALU_SLTU_EN, 0 without it.
